// File: rtl/addsub_seq.sv
// Multi-cycle W-bit adder/subtractor built from one 8-bit slice reused once per byte,
// LSB first, with the inter-slice carry held in a register.
module addsub_seq #(
  parameter int unsigned SLICES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [8*SLICES-1:0]   a,
  input  logic [8*SLICES-1:0]   b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [8*SLICES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int unsigned W   = 8 * SLICES;
  localparam int unsigned K_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic           c_q, c_d;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   result_d;
  logic           carry_out_d, overflow_d;
  logic           load;

  logic [7:0]     slice_x, slice_y, slice_sum;
  logic [8:0]     slice_xy;
  logic           slice_p, slice_g, slice_cout;

  // Shared 8-bit slice: group generate/propagate plus carry-in folded into the sum
  always_comb begin
    slice_x    = a_q[{k_q, 3'b000} +: 8];
    slice_y    = b_q[{k_q, 3'b000} +: 8];
    slice_xy   = {1'b0, slice_x} + {1'b0, slice_y};
    slice_g    = slice_xy[8];
    slice_p    = &(slice_x | slice_y);
    slice_sum  = slice_xy[7:0] + 8'(c_q);
    slice_cout = slice_g | (slice_p & c_q);
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    c_d         = c_q;
    result_d    = result;
    carry_out_d = carry_out;
    overflow_d  = overflow;
    load        = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          c_d     = op_sub;
          k_d     = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[{k_q, 3'b000} +: 8] = slice_sum;
        c_d = slice_cout;
        k_d = k_q + K_W'(1);
        if (k_q == K_LAST) begin
          k_d         = '0;
          state_d     = DONE;
          carry_out_d = slice_cout;
          overflow_d  = (a_q[W-1] == b_q[W-1]) & (slice_sum[7] != a_q[W-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      c_q       <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      c_q       <= c_d;
      result    <= result_d;
      carry_out <= carry_out_d;
      overflow  <= overflow_d;
    end
  end

  // Operand latches; B is stored pre-inverted for subtraction
  always_ff @(posedge clock) begin
    if (load) begin
      a_q <= a;
      b_q <= b ^ {W{op_sub}};
    end
  end

  assign busy  = (state_q == RUN);
  assign ready = (state_q != RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: vector table, random ops against an arithmetic
// model, and hand-written sequences for mid-run start, back-to-back and reset abort.
module tb_addsub_seq;

  localparam int unsigned SLICES = 4;
  localparam int unsigned W      = 8 * SLICES;
  localparam int unsigned LAT    = SLICES + 1;

  logic         clock = 1'b0;
  logic         reset, start, op_sub;
  logic [W-1:0] a, b;
  logic         ready, busy, done, carry_out, overflow;
  logic [W-1:0] result;

  addsub_seq #(.SLICES(SLICES)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference arithmetic, computed from plain integer add/subtract and signed range
  function automatic exp_t model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    logic [W:0] s;
    longint sx, sy, f;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op) begin
      e.res = x - y;
      e.co  = (x >= y);
      f     = sx - sy;
    end else begin
      s     = {1'b0, x} + {1'b0, y};
      e.res = s[W-1:0];
      e.co  = s[W];
      f     = sx + sy;
    end
    e.ov = (f > 64'sd2147483647) || (f < -64'sd2147483648);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 result=0x%0h, expected no done", result);
      end else begin
        got = sb.pop_front();
        check("result", result, got.res);
        check("carry_out", W'(carry_out), W'(got.co));
        check("overflow", W'(overflow), W'(got.ov));
      end
    end
  end

  // Called right after a rising edge: drive one start cycle and queue the expectation
  task automatic issue(input logic op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e);
    start  = 1'b1;
    op_sub = op;
    a      = x;
    b      = y;
    sb.push_back(e);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Wait for done; n0 is the cycle index (1 = cycle after the start edge) of the next negedge
  task automatic wait_done(input string name, input int n0);
    int n = n0;
    int nbusy = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) nbusy++;
      n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in 20 cycles, expected done", name);
    end else begin
      check({name, "_latency"}, W'(n), W'(LAT));
      check({name, "_busy_cycles"}, W'(nbusy), W'(SLICES + 1 - n0));
      check({name, "_ready"}, W'(ready), W'(1));
    end
  endtask

  initial begin
    exp_t e;
    logic op;
    logic [W-1:0] x, y;

    tbl[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_result", result, '0);
    check("rst_done", W'(done), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_ready", W'(ready), W'(1));
    check("rst_carry_out", W'(carry_out), W'(0));
    check("rst_overflow", W'(overflow), W'(0));
    @(posedge clock);
    #1;

    for (int i = 0; i < 8; i++) begin
      e = '{tbl[i].res, tbl[i].co, tbl[i].ov};
      issue(tbl[i].op, tbl[i].x, tbl[i].y, e);
      wait_done($sformatf("vec%0d", i), 1);
      @(posedge clock);
      #1;
    end

    // Result is held after returning to IDLE
    @(negedge clock);
    check("hold_result", result, tbl[7].res);
    check("hold_done", W'(done), W'(0));
    @(posedge clock);
    #1;

    for (int i = 0; i < 6; i++) begin
      op = 1'($urandom_range(0, 1));
      x  = $urandom;
      y  = $urandom;
      issue(op, x, y, model(op, x, y));
      wait_done($sformatf("rand%0d", i), 1);
      @(posedge clock);
      #1;
    end

    // start and operand changes during RUN are ignored
    issue(1'b0, 32'h0102_0304, 32'h1020_3040, '{32'h1122_3344, 1'b0, 1'b0});
    @(posedge clock);
    #1;
    start = 1'b1; op_sub = 1'b1; a = '1; b = '1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done("ignore", 3);

    // Back-to-back start in the DONE cycle
    start = 1'b1; op_sub = 1'b1; a = 32'h0000_0100; b = 32'h0000_0001;
    sb.push_back('{32'h0000_00FF, 1'b1, 1'b0});
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    check("b2b_done_low", W'(done), W'(0));
    check("b2b_busy", W'(busy), W'(1));
    wait_done("b2b", 2);
    repeat (3) @(posedge clock);
    #1;

    // Reset while k=2 discards the operation
    start = 1'b1; op_sub = 1'b0; a = 32'hAAAA_AAAA; b = 32'h5555_5555;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_result", result, '0);
    check("abort_busy", W'(busy), W'(0));
    check("abort_ready", W'(ready), W'(1));
    check("abort_done", W'(done), W'(0));
    repeat (8) @(negedge clock);
    @(posedge clock);
    #1;
    issue(1'b0, 32'h1234_5678, 32'h1111_1111, '{32'h2345_6789, 1'b0, 1'b0});
    wait_done("post_abort", 1);
    @(posedge clock);
    #1;

    check("sb_empty", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 Parameter: SLICES, default 4, number of 8-bit slices; operand width W = 8*SLICES.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
REQ-004 start  input  1  request; accepted only when ready=1.
REQ-005 op_sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 a  input  W  operand A; sampled with start.
REQ-007 b  input  W  operand B; sampled with start.
REQ-008 ready  output  1  high in IDLE and DONE; new start acceptable.
REQ-009 busy  output  1  high while any slice state is active.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  W  sum/difference; held from done until next accepted start or reset.
REQ-012 carry_out  output  1  carry out of MSB (subtract: 1 = no borrow); held like result.
REQ-013 overflow  output  1  signed two's-complement overflow; held like result.

Function
REQ-014 Datapath: exactly one 8-bit adder slice, reused once per slice; no W-bit adder.
REQ-015 Slice produces an 8-bit sum plus group propagate P (AND of x|y) and group generate G; slice carry-out = G | (P & cin), registered in carry register C.
REQ-016 FSM states: IDLE, RUN, DONE; slice index k is a counter, 0..SLICES-1.
REQ-017 IDLE/DONE with start=1: latch a, b ^ {W{op_sub}}, op_sub; C <= op_sub; k <= 0; go to RUN.
REQ-018 DONE with start=0: go to IDLE; done drops after exactly one cycle.
REQ-019 RUN, each edge: result[8k+7:8k] <= slice sum of latched byte k with cin=C; C <= slice carry-out; k <= k+1.
REQ-020 RUN with k=SLICES-1: also go to DONE; carry_out <= slice carry-out; overflow <= (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]), where B' is the latched, possibly inverted, operand.
REQ-021 Latency: start sampled at edge N; done=1 in the cycle after edge N+SLICES; for SLICES=4, done is high 5 cycles after the start cycle.
REQ-022 start while busy=1 is ignored and not queued; changes on a, b and op_sub during RUN have no effect.
REQ-023 start in the DONE cycle is accepted: back-to-back operation, done low in the next cycle.
REQ-024 result bytes not yet written in RUN keep their previous values; result is only guaranteed when done=1 and thereafter.
REQ-025 busy = (state==RUN); ready = (state!=RUN); done = (state==DONE).

Reset
REQ-026 reset=1 at an edge: state IDLE, k=0, C=0, result=0, carry_out=0, overflow=0, done=0, busy=0, ready=1.
REQ-027 reset overrides start and an in-progress RUN: partial results are discarded and no done pulse follows.
REQ-028 Latched operand registers need no reset value; none is required.

Verification
REQ-029 Reset -> result=0x00000000, done=0, busy=0, ready=1, carry_out=0, overflow=0.
REQ-030 add 0x000000FF+0x00000001 -> 0x00000100, carry_out=0, overflow=0; done exactly 5 cycles after start; busy high 4 cycles.
REQ-031 add 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow=1, carry_out=0; add 0xFFFFFFFF+0x00000001 -> 0x00000000, carry_out=1, overflow=0.
REQ-032 sub 0x00000005-0x00000003 -> 0x00000002, carry_out=1; sub 0x00000000-0x00000001 -> 0xFFFFFFFF, carry_out=0; sub 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow=1.
REQ-033 start pulsed and a/b toggled mid-RUN -> ignored, original result unchanged; start in DONE cycle -> second result after 4 more cycles, with no idle gap.
REQ-034 reset asserted while k=2 -> IDLE next cycle, result=0, no done; a subsequent add 0x12345678+0x11111111 -> 0x23456789.
